// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: load/store types, FSM states,
// and the alignment rule used when the misalignment trap is built in.
package mem_pkg;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LBU = 3'd1;
  localparam logic [2:0] LOAD_LH  = 3'd2;
  localparam logic [2:0] LOAD_LHU = 3'd3;
  localparam logic [2:0] LOAD_LW  = 3'd4;

  localparam logic [1:0] STORE_SB = 2'd0;
  localparam logic [1:0] STORE_SH = 2'd1;
  localparam logic [1:0] STORE_SW = 2'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] lt,
                                         input logic [1:0] st,
                                         input logic [1:0] off);
    if (is_store)
      return (st == STORE_SH && off[0]) || (st == STORE_SW && off != 2'b00);
    return ((lt == LOAD_LH || lt == LOAD_LHU) && off[0]) ||
           (lt == LOAD_LW && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                  input  dmem_ready, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                  output dmem_ready, dmem_rdata);
endinterface

// File: rtl/load_formatter.sv
// Picks the addressed byte/halfword/word out of a little-endian read word and extends it.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{offset, 3'b000} +: 8];
    w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LOAD_LB:  result = {{24{w_byte[7]}}, w_byte};
      LOAD_LBU: result = {24'h0, w_byte};
      LOAD_LH:  result = {{16{w_half[15]}}, w_half};
      LOAD_LHU: result = {16'h0, w_half};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE -> ACCESS -> DONE handshake with data memory.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                load_type,
  input  logic [1:0]                store_type,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  output logic                      stall,
  output logic [31:0]               load_result,
  output logic                      result_valid,
  output logic                      misalign_err,
  mem_access_unit_if.master         dmem
);

  state_t      r_state;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_off;
  logic [2:0]  r_load_type;
  logic [31:0] r_load_result;
  logic        r_misalign;

  logic        w_access;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_fmt;

  assign w_access = valid_in && (mem_read || mem_write);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(mem_write, load_type, store_type, addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // mem_write wins when both direction bits are set
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (mem_write) begin
      case (store_type)
        STORE_SB: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        STORE_SH: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        default: w_wdata = store_data;
      endcase
    end
  end

  load_formatter u_fmt (
    .rdata     (dmem.dmem_rdata),
    .offset    (r_off),
    .load_type (r_load_type),
    .result    (w_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_we          <= 1'b0;
      r_be          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_off         <= '0;
      r_load_type   <= '0;
      r_load_result <= '0;
      r_misalign    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_access) begin
          r_we        <= mem_write;
          r_be        <= w_be;
          r_addr      <= {addr[31:2], 2'b00};
          r_wdata     <= w_wdata;
          r_off       <= addr[1:0];
          r_load_type <= load_type;
          r_misalign  <= w_misalign;
          r_state     <= w_misalign ? ST_DONE : ST_ACCESS;
        end
        ST_ACCESS: if (dmem.dmem_ready) begin
          r_state <= ST_DONE;
          if (!r_we) r_load_result <= w_fmt;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall        = (r_state == ST_IDLE && w_access) || (r_state == ST_ACCESS);
  assign result_valid = (r_state == ST_DONE) && !r_misalign;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err = (r_state == ST_DONE) && r_misalign;
`else
  assign misalign_err = 1'b0;
`endif
  assign load_result  = r_load_result;

  assign dmem.dmem_req   = (r_state == ST_ACCESS);
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

endmodule
